mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN (see mem_arbiter.sv).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  // Requester indices: 0 is the SPI slave FSM, 1 is the host port.
  localparam logic REQ_SPI  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection: a lone request wins outright, a tie goes to the
// requester that was not granted most recently.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Pick the winner; with no request the output is a don't-care (SPI).
  always_comb begin
    winner = REQ_SPI;
    if (req0 && req1) begin
      winner = (last == REQ_HOST) ? REQ_SPI : REQ_HOST;
    end else if (req1) begin
      winner = REQ_HOST;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port data memory between the SPI slave FSM
// (requester 0) and the host port (requester 1).
// Build option: MEM_ARB_FIXED_PRIO_EN -- requester 0 always wins ties and the
// last-grant flag is not built; otherwise ties alternate round-robin.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
// stable until gntN. gntN is a one-cycle pulse marking the cycle the memory
// is driven; the transaction is then committed from latched values even if
// reqN drops. A request dropped before gntN is forgotten. For reads, rvalidN
// pulses for one cycle (the cycle after gntN) with the word on rdata.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              busy,
  output logic [1:0]        dbgState
);

  state_t            state;
  logic              owner;
  logic              pickWinner;
  logic              pickLast;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Presenting "host was last" makes every tie resolve to SPI.
  assign pickLast = REQ_HOST;
`else
  logic lastGnt;
  assign pickLast = lastGnt;
`endif

  arb_pick2 uPick (
    .req0   (req0),
    .req1   (req1),
    .last   (pickLast),
    .winner (pickWinner)
  );

  // Route the winning requester's command toward the latch.
  always_comb begin
    selWe    = we0;
    selAddr  = addr0;
    selWdata = wdata0;
    if (pickWinner == REQ_HOST) begin
      selWe    = we1;
      selAddr  = addr1;
      selWdata = wdata1;
    end
  end

  // Control FSM with registered outputs. dm_we/dm_addr/dm_wdata double as
  // the latched command during ACCESS. The memory returns read data by the
  // edge that closes ACCESS, so that edge loads rdata and raises rvalid,
  // making the response visible for the whole RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= REQ_SPI;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rdata    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      lastGnt  <= REQ_HOST;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      dm_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= ACCESS;
            owner    <= pickWinner;
            gnt0     <= (pickWinner == REQ_SPI);
            gnt1     <= (pickWinner == REQ_HOST);
            dm_we    <= selWe;
            dm_addr  <= selAddr;
            dm_wdata <= selWdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
            lastGnt  <= pickWinner;
`endif
          end
        end
        ACCESS: begin
          dm_addr  <= '0;
          dm_wdata <= '0;
          if (dm_we) begin
            state <= IDLE;
          end else begin
            state   <= RESP;
            rdata   <= dm_rdata;
            rvalid0 <= (owner == REQ_SPI);
            rvalid1 <= (owner == REQ_HOST);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset checks, a vector table of single
// transactions, hand-written multi-cycle corner cases and a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          dmWe;
  logic [AW-1:0] dmAddr;
  logic [DW-1:0] dmWdata, dmRdata;
  logic          busy;
  logic [1:0]    dbgState;

  // Clock / memory model ------------------------------------------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:127];
  logic          preWe = 1'b0;
  logic [AW-1:0] preAddr = '0;
  logic [DW-1:0] preData = '0;

  // Memory read data settles within the cycle the address is driven.
  assign dmRdata = mem[dmAddr];
  always @(posedge clk) begin
    if (dmWe) mem[dmAddr] <= dmWdata;
    else if (preWe) mem[preAddr] <= preData;
  end

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .busy(busy), .dbgState(dbgState)
  );

  // Scoreboard ----------------------------------------------------------
  int            nChecks = 0;
  int            nFail = 0;
  logic [DW-1:0] expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks --------------------------------------------------------
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic rstPulse();
    clearReqs();
    rst_n = 1'b0;
    stepEdge();
    stepEdge();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          r0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          win;
    logic [DW-1:0] rd;
    logic          winFix;
    logic [DW-1:0] rdFix;
  } vec_t;

  vec_t vecs[8];

  // One transaction from IDLE: grant cycle, then response or completion.
  task automatic runTxn(input int row, input vec_t v, input logic win, input logic [DW-1:0] expRd);
    logic          wWe;
    logic [AW-1:0] wA;
    logic [DW-1:0] wD;
    wWe = win ? v.we1 : v.we0;
    wA  = win ? v.a1 : v.a0;
    wD  = win ? v.d1 : v.d0;
    req0 = v.r0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1;
    if (!wWe) expQ.push_back(expRd);
    stepEdge();
    check($sformatf("row%0d gnt", row), 32'({gnt1, gnt0}), win ? 32'd2 : 32'd1);
    check($sformatf("row%0d dm_we", row), 32'(dmWe), 32'(wWe));
    check($sformatf("row%0d dm_addr", row), 32'(dmAddr), 32'(wA));
    if (wWe) check($sformatf("row%0d dm_wdata", row), 32'(dmWdata), 32'(wD));
    check($sformatf("row%0d busy", row), 32'(busy), 32'd1);
    clearReqs();
    stepEdge();
    check($sformatf("row%0d gnt low", row), 32'({gnt1, gnt0}), 32'd0);
    check($sformatf("row%0d dm_we low", row), 32'(dmWe), 32'd0);
    if (!wWe) begin
      logic [DW-1:0] e;
      e = expQ.pop_front();
      check($sformatf("row%0d rvalid", row), 32'({rvalid1, rvalid0}), win ? 32'd2 : 32'd1);
      check($sformatf("row%0d rdata", row), 32'(rdata), 32'(e));
      stepEdge();
      check($sformatf("row%0d rvalid low", row), 32'({rvalid1, rvalid0}), 32'd0);
      check($sformatf("row%0d busy end", row), 32'(busy), 32'd0);
      check($sformatf("row%0d rdata hold", row), 32'(rdata), 32'(e));
    end else begin
      check($sformatf("row%0d no rvalid", row), 32'({rvalid1, rvalid0}), 32'd0);
      check($sformatf("row%0d busy end", row), 32'(busy), 32'd0);
      check($sformatf("row%0d mem written", row), 32'(mem[wA]), 32'(wD));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            order[4];
    int            seen;
    logic [DW-1:0] modelMem [0:127];
    logic [1:0]    sG[4], sRv[4];
    logic          sWe[4];
    logic [AW-1:0] sA[4];
    logic [DW-1:0] sD[4];
    logic [DW-1:0] expRdata;
    int            freeAt;
    logic          lastW;

    // Reset with preload; requests driven high must not leak through.
    clearReqs();
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) begin
      preWe = 1'b1; preAddr = AW'(i); preData = DW'(i * 3 + 2);
      stepEdge();
    end
    preWe = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h11; wdata0 = 8'h22;
    req1 = 1'b1;
    stepEdge();
    check("reset gnt", 32'({gnt1, gnt0}), 32'd0);
    check("reset rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check("reset dm_we", 32'(dmWe), 32'd0);
    check("reset dm_addr", 32'(dmAddr), 32'd0);
    check("reset dm_wdata", 32'(dmWdata), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset state", 32'(dbgState), 32'd0);
    clearReqs();
    rst_n = 1'b1;

    // Vector table (round-robin expectations, then fixed-priority ones).
    vecs[0] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 7'h12, 8'hA5, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h12, 8'h00, 1'b1, 8'hA5, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 7'h20, 8'h5A, 1'b1, 1'b1, 7'h21, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 7'h21, 8'h00, 1'b1, 1'b0, 7'h20, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h65};
    vecs[4] = '{1'b1, 1'b0, 7'h20, 8'h00, 1'b1, 1'b1, 7'h21, 8'h77, 1'b0, 8'h5A, 1'b0, 8'h5A};
    vecs[5] = '{1'b1, 1'b1, 7'h21, 8'h99, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 7'h21, 8'h00, 1'b1, 1'b0, 7'h12, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h99};
    vecs[7] = '{1'b1, 1'b0, 7'h21, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h99, 1'b0, 8'h99};
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      runTxn(i, vecs[i], vecs[i].winFix, vecs[i].rdFix);
`else
      runTxn(i, vecs[i], vecs[i].win, vecs[i].rd);
`endif
    end

    // Both requesters held high after reset: grant order.
    rstPulse();
    req0 = 1'b1; req1 = 1'b1;
    order = '{-1, -1, -1, -1};
    seen = 0;
    for (int k = 0; k < 30 && seen < 4; k++) begin
      stepEdge();
      check("tie gnt exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0 || gnt1) begin
        order[seen] = gnt1 ? 1 : 0;
        seen++;
      end
    end
    check("tie grant count", 32'(seen), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      check($sformatf("tie order %0d", i), 32'(order[i]), 32'd0);
`else
      check($sformatf("tie order %0d", i), 32'(order[i]), 32'(i % 2));
`endif
    end
    clearReqs();
    repeat (3) stepEdge();

    // Same-cycle read (req0) and write (req1) to address 5.
    rstPulse();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h05; wdata1 = 8'h3C;
    stepEdge();
    check("rw gnt0", 32'({gnt1, gnt0}), 32'd1);
    check("rw read dm_we", 32'(dmWe), 32'd0);
    check("rw read dm_addr", 32'(dmAddr), 32'h05);
    req0 = 1'b0;
    stepEdge();
    check("rw rvalid0", 32'({rvalid1, rvalid0}), 32'd1);
    check("rw old data", 32'(rdata), 32'h11);
    stepEdge();
    check("rw resp done", 32'({gnt1, gnt0, rvalid1, rvalid0}), 32'd0);
    stepEdge();
    check("rw gnt1", 32'({gnt1, gnt0}), 32'd2);
    check("rw write dm_we", 32'(dmWe), 32'd1);
    check("rw write dm_wdata", 32'(dmWdata), 32'h3C);
    clearReqs();
    stepEdge();
    check("rw dm_we drop", 32'(dmWe), 32'd0);
    check("rw mem", 32'(mem[5]), 32'h3C);

    // Reset during the ACCESS cycle of a write.
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h40; wdata1 = 8'hEE;
    stepEdge();
    check("rst-mid gnt1", 32'(gnt1), 32'd1);
    check("rst-mid dm_we", 32'(dmWe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst-mid async dm_we", 32'(dmWe), 32'd0);
    check("rst-mid busy", 32'(busy), 32'd0);
    check("rst-mid gnt", 32'({gnt1, gnt0}), 32'd0);
    clearReqs();
    stepEdge();
    stepEdge();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepEdge();
      check("rst-mid no gnt/rvalid", 32'({gnt1, gnt0, rvalid1, rvalid0}), 32'd0);
      check("rst-mid idle", 32'(busy), 32'd0);
    end
    check("rst-mid mem unchanged", 32'(mem[7'h40]), 32'hC2);

    // req0 pulsed for one cycle while a req1 read sits in RESP.
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h12;
    stepEdge();
    check("drop gnt1", 32'({gnt1, gnt0}), 32'd2);
    clearReqs();
    stepEdge();
    check("drop in RESP", 32'(dbgState), 32'd2);
    check("drop rvalid1", 32'({rvalid1, rvalid0}), 32'd2);
    check("drop rdata", 32'(rdata), 32'hA5);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h30; wdata0 = 8'hFF;
    stepEdge();
    clearReqs();
    for (int k = 0; k < 3; k++) begin
      stepEdge();
      check("drop no gnt0", 32'({gnt1, gnt0}), 32'd0);
      check("drop no dm_we", 32'(dmWe), 32'd0);
    end
    check("drop mem unchanged", 32'(mem[7'h30]), 32'h92);

    // Randomized run against a transaction-level model: a request seen in
    // IDLE at edge c is granted at c, a read answers at c+1, and the next
    // request can be taken at c+2 (write) or c+3 (read).
    rstPulse();
    for (int i = 0; i < 128; i++) modelMem[i] = mem[i];
    for (int i = 0; i < 4; i++) begin
      sG[i] = '0; sRv[i] = '0; sWe[i] = 1'b0; sA[i] = '0; sD[i] = '0;
    end
    expRdata = '0;
    freeAt = 0;
    lastW = 1'b1;
    for (int c = 0; c < 303; c++) begin
      int   s;
      logic w, tWe;
      logic [AW-1:0] tA;
      logic [DW-1:0] tD;
      s = c % 4;
      if (c < 300) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 127)); wdata0 = DW'($urandom_range(0, 255));
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 127)); wdata1 = DW'($urandom_range(0, 255));
      end else begin
        clearReqs();
      end
      if (c >= freeAt && (req0 || req1)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = req0 ? 1'b0 : 1'b1;
`else
        if (req0 && req1) w = ~lastW;
        else w = req1;
`endif
        lastW = w;
        tWe = w ? we1 : we0;
        tA  = w ? addr1 : addr0;
        tD  = w ? wdata1 : wdata0;
        sG[s] = w ? 2'd2 : 2'd1;
        sWe[s] = tWe;
        sA[s] = tA;
        sD[s] = tD;
        if (tWe) begin
          modelMem[tA] = tD;
          freeAt = c + 2;
        end else begin
          sRv[(c + 1) % 4] = w ? 2'd2 : 2'd1;
          expQ.push_back(modelMem[tA]);
          freeAt = c + 3;
        end
      end
      stepEdge();
      if (sRv[s] != 2'd0 && expQ.size() > 0) expRdata = expQ.pop_front();
      check("rnd gnt", 32'({gnt1, gnt0}), 32'(sG[s]));
      check("rnd rvalid", 32'({rvalid1, rvalid0}), 32'(sRv[s]));
      check("rnd dm_we", 32'(dmWe), 32'(sWe[s]));
      check("rnd busy", 32'(busy), 32'(c < freeAt - 1));
      check("rnd rdata", 32'(rdata), 32'(expRdata));
      if (sG[s] != 2'd0) begin
        check("rnd dm_addr", 32'(dmAddr), 32'(sA[s]));
        if (sWe[s]) check("rnd dm_wdata", 32'(dmWdata), 32'(sD[s]));
      end
      sG[s] = '0; sRv[s] = '0; sWe[s] = 1'b0;
    end
    check("rnd queue drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
